// File: rtl/encoder_pkg.sv
// Shared state encoding and default widths for the vocab encoder path.
// Optional miss statistics are enabled with ENCODER_STATS_EN.
package encoder_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int VOCAB_AW   = 4;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SCAN,
      EMIT,
      FIN
   } enc_state_e;

endpackage

// File: rtl/vocab_matcher.sv
// Vocab scan: address generator plus one-cycle-delayed compare against
// the latched symbol. First match wins; a miss on the last index ends.
module vocab_matcher
   import encoder_pkg::*;
#(
   parameter int DATA_WIDTH = encoder_pkg::DATA_WIDTH,
   parameter int VOCAB_AW   = encoder_pkg::VOCAB_AW,
   parameter logic [DATA_WIDTH-1:0] UNK_CODE = '1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [VOCAB_AW-1:0]   voc_addr,
   input  logic [DATA_WIDTH-1:0] voc_data,
   input  logic [DATA_WIDTH-1:0] code_data,
   output logic                  res_valid,
   output logic                  res_hit,
   output logic [DATA_WIDTH-1:0] res_code
);

   localparam logic [VOCAB_AW-1:0] LAST = '1;

   logic                  active;
   logic                  load;
   logic [DATA_WIDTH-1:0] sym;
   logic [VOCAB_AW-1:0]   idx;
   logic                  cmp;
   logic                  eq;

   assign cmp       = active & ~load;
   assign eq        = (voc_data == sym);
   assign res_hit   = cmp & eq;
   assign res_valid = cmp & (eq | (idx == LAST));
   assign res_code  = eq ? code_data : UNK_CODE;

   // idx trails voc_addr by one cycle to line up with the SRAM dout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active   <= 1'b0;
         load     <= 1'b0;
         sym      <= '0;
         idx      <= '0;
         voc_addr <= '0;
      end else if (start) begin
         active   <= 1'b1;
         load     <= 1'b1;
         voc_addr <= '0;
      end else if (active) begin
         idx <= voc_addr;
         if (voc_addr != LAST)
            voc_addr <= voc_addr + 1'b1;
         if (load) begin
            sym  <= in_data;
            load <= 1'b0;
         end
         if (res_valid)
            active <= 1'b0;
      end
   end

endmodule

// File: rtl/vocab_encoder.sv
// Streams vocab codes for each buffered symbol over a valid/ready port.
// Define ENCODER_STATS_EN to build the per-job miss counter (miss_cnt).
module vocab_encoder
   import encoder_pkg::*;
#(
   parameter int DATA_WIDTH = encoder_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = encoder_pkg::ADDR_WIDTH,
   parameter int VOCAB_AW   = encoder_pkg::VOCAB_AW,
   parameter logic [DATA_WIDTH-1:0] UNK_CODE = '1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic [ADDR_WIDTH:0]   len,
   output logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [VOCAB_AW-1:0]   voc_addr,
   input  logic [DATA_WIDTH-1:0] voc_data,
   input  logic [DATA_WIDTH-1:0] code_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_code,
   output logic                  out_hit,
   output logic                  busy,
   output logic                  done
`ifdef ENCODER_STATS_EN
   ,
   output logic [ADDR_WIDTH:0]   miss_cnt
`endif
);

   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

   enc_state_e            state;
   enc_state_e            state_nx;
   logic [ADDR_WIDTH:0]   idx;
   logic [ADDR_WIDTH:0]   idx_nx;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   len_cl;
   logic                  start;
   logic                  accept;
   logic                  m_valid;
   logic                  m_hit;
   logic [DATA_WIDTH-1:0] m_code;

   assign len_cl  = (len > MAX_LEN) ? MAX_LEN : len;
   assign start   = (state == IDLE) & cs;
   assign accept  = (state == EMIT) & out_valid & out_ready;
   assign idx_nx  = idx + 1'b1;
   assign in_addr = idx[ADDR_WIDTH-1:0];

   vocab_matcher #(
      .DATA_WIDTH (DATA_WIDTH),
      .VOCAB_AW   (VOCAB_AW),
      .UNK_CODE   (UNK_CODE)
   ) u_matcher (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (state == FETCH),
      .in_data   (in_data),
      .voc_addr  (voc_addr),
      .voc_data  (voc_data),
      .code_data (code_data),
      .res_valid (m_valid),
      .res_hit   (m_hit),
      .res_code  (m_code)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (cs) state_nx = (len_cl == '0) ? FIN : FETCH;
         FETCH: state_nx = SCAN;
         SCAN:  if (m_valid) state_nx = EMIT;
         EMIT:  if (accept) state_nx = (idx_nx == len_q) ? FIN : FETCH;
         FIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         len_q     <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         out_hit   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= (state == FIN);
         if (start) begin
            len_q <= len_cl;
            idx   <= '0;
            busy  <= 1'b1;
         end
         if (state == FIN)
            busy <= 1'b0;
         if ((state == SCAN) && m_valid) begin
            out_valid <= 1'b1;
            out_code  <= m_code;
            out_hit   <= m_hit;
         end
         if (accept) begin
            out_valid <= 1'b0;
            idx       <= idx_nx;
         end
      end
   end

`ifdef ENCODER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         miss_cnt <= '0;
      else if (start)
         miss_cnt <= '0;
      else if (accept && !out_hit)
         miss_cnt <= miss_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_vocab_encoder.sv
// Directed bench for vocab_encoder with behavioural word/vocab/code SRAMs.
// Miss-counter checks are built when ENCODER_STATS_EN is defined.
module tb_vocab_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs = 1'b0;
   logic [4:0] len = '0;
   logic [3:0] in_addr;
   logic [7:0] in_data = '0;
   logic [3:0] voc_addr;
   logic [7:0] voc_data = '0;
   logic [7:0] code_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_code;
   logic       out_hit;
   logic       busy;
   logic       done;
`ifdef ENCODER_STATS_EN
   logic [4:0] miss_cnt;
`endif

   logic [7:0] word_mem [16];
   logic [7:0] vocab_mem [16];
   logic [7:0] code_mem [16];

   int checks = 0;
   int errors = 0;
   int beats, done_at, first_v, busy_n, addr_at1;
   logic [7:0] bcode [32];
   logic       bhit [32];

   vocab_encoder dut (
`ifdef ENCODER_STATS_EN
      .miss_cnt  (miss_cnt),
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (cs),
      .len       (len),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .voc_addr  (voc_addr),
      .voc_data  (voc_data),
      .code_data (code_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_hit   (out_hit),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      in_data   <= word_mem[in_addr];
      voc_data  <= vocab_mem[voc_addr];
      code_data <= code_mem[voc_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One job: cs pulse, then watch until done or budget runs out.
   task automatic run(input logic [4:0] l, input int stall_beat,
                      input int stall_n, input int budget);
      int stall;
      logic [7:0] held;
      stall = 0;
      held = '0;
      beats = 0;
      done_at = -1;
      first_v = -1;
      busy_n = 0;
      addr_at1 = -1;
      for (int k = 0; k < 32; k++) begin
         bcode[k] = '0;
         bhit[k] = 1'b0;
      end
      @(negedge clk);
      cs = 1'b1;
      len = l;
      out_ready = 1'b1;
      for (int n = 1; n <= budget && done_at < 0; n++) begin
         @(negedge clk);
         cs = 1'b0;
         if (n == 1) addr_at1 = int'(in_addr);
         if (busy) busy_n++;
         if (done) done_at = n;
         if (out_valid) begin
            if (first_v < 0) first_v = n;
            if (beats == stall_beat && stall < stall_n) begin
               if (stall == 0) held = out_code;
               else check("stall_hold", out_code, held);
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = 1'b1;
               if (beats < 32) begin
                  bcode[beats] = out_code;
                  bhit[beats] = out_hit;
               end
               beats++;
            end
         end else begin
            out_ready = 1'b1;
         end
      end
      out_ready = 1'b1;
      check("done_seen", done_at >= 0, 1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         vocab_mem[i] = 8'(10 * (i + 1));
         code_mem[i]  = 8'(100 + i);
         word_mem[i]  = '0;
      end

      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_addr", in_addr, 0);
      check("rst_voc_addr", voc_addr, 0);
      check("rst_code", out_code, 0);
      check("rst_hit", out_hit, 0);
`ifdef ENCODER_STATS_EN
      check("rst_miss", miss_cnt, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // single hit at index 1
      word_mem[0] = 8'd20;
      run(5'd1, -1, 0, 100);
      check("t1_beats", beats, 1);
      check("t1_code", bcode[0], 8'd101);
      check("t1_hit", bhit[0], 1);
      check("t1_latency", first_v, 5);
      check("t1_done_at", done_at, 7);
      check("t1_busy", busy_n, 6);
      @(negedge clk);
      check("t1_done_pulse", done, 0);

      // miss scans the whole vocab
      word_mem[0] = 8'd99;
      run(5'd1, -1, 0, 100);
      check("t2_beats", beats, 1);
      check("t2_code", bcode[0], 8'hFF);
      check("t2_hit", bhit[0], 0);
      check("t2_latency", first_v, 19);
`ifdef ENCODER_STATS_EN
      check("t2_miss", miss_cnt, 1);
`endif

      // duplicate entry: lowest index wins
      vocab_mem[5] = 8'd30;
      word_mem[0] = 8'd30;
      run(5'd1, -1, 0, 100);
      check("t3_code", bcode[0], 8'd102);
      check("t3_hit", bhit[0], 1);
      check("t3_latency", first_v, 6);

      // three beats, back-pressure on the second
      word_mem[0] = 8'd10;
      word_mem[1] = 8'd40;
      word_mem[2] = 8'd99;
      run(5'd3, 1, 4, 200);
      check("t4_beats", beats, 3);
      check("t4_code0", bcode[0], 8'd100);
      check("t4_code1", bcode[1], 8'd103);
      check("t4_code2", bcode[2], 8'hFF);
      check("t4_hit0", bhit[0], 1);
      check("t4_hit1", bhit[1], 1);
      check("t4_hit2", bhit[2], 0);
`ifdef ENCODER_STATS_EN
      check("t4_miss", miss_cnt, 1);
`endif

      // empty job
      run(5'd0, -1, 0, 20);
      check("t5_done_at", done_at, 2);
      check("t5_busy", busy_n, 1);
      check("t5_no_valid", first_v, 32'hFFFF_FFFF);
      check("t5_beats", beats, 0);

      // oversize length clamps to 16
      vocab_mem[5] = 8'd60;
      for (int j = 0; j < 16; j++) word_mem[j] = 8'(10 * (j + 1));
      run(5'd31, -1, 0, 1000);
      check("t7_beats", beats, 16);
      check("t7_first", bcode[0], 8'd100);
      check("t7_last", bcode[15], 8'd115);

      // reset during the second symbol's scan
      word_mem[0] = 8'd20;
      word_mem[1] = 8'd99;
      @(negedge clk);
      cs = 1'b1;
      len = 5'd2;
      out_ready = 1'b1;
      @(negedge clk);
      cs = 1'b0;
      repeat (7) @(negedge clk);
      check("t6_pre_addr", in_addr, 1);
      check("t6_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6_valid", out_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_in_addr", in_addr, 0);
      check("t6_voc_addr", voc_addr, 0);
      check("t6_code", out_code, 0);
      check("t6_hit", out_hit, 0);
      repeat (2) @(negedge clk);
      check("t6_no_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run(5'd1, -1, 0, 100);
      check("t6_restart_addr", addr_at1, 0);
      check("t6_restart_code", bcode[0], 8'd101);
      check("t6_restart_done", done_at, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
